// File: rtl/fpnew_opgroup_slice_arbiter_pkg.sv
// Shared defaults and index helpers for the opgroup slice arbiter.
package fpnew_opgroup_slice_arbiter_pkg;

  localparam int unsigned DefaultNumReq         = 4;
  localparam int unsigned DefaultOpWidth        = 128;
  localparam int unsigned DefaultResWidth       = 72;
  localparam int unsigned DefaultMaxOutstanding = 4;

  // (a + b) mod m, for walking requester indices around the ring.
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned m);
    return (a + b) % m;
  endfunction

endpackage

// File: rtl/fpnew_opgroup_slice_arbiter_id_fifo.sv
// In-order FIFO of issued requester IDs; occupancy kept in a separate counter.
module fpnew_slice_id_fifo #(
  parameter int unsigned  Depth    = 4,
  parameter int unsigned  Width    = 2,
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [Width-1:0]    push_data_i,
  input  logic                pop_i,
  input  logic                clear_i,
  output logic [Width-1:0]    head_o,
  output logic [CntWidth-1:0] count_o
);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + CntWidth'(1);
      end else if (pop_i && !push_i) begin
        count_q <= count_q - CntWidth'(1);
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fpnew_opgroup_slice_arbiter.sv
// Round-robin sharing of one in-order opgroup slice between NumReq requesters,
// with results steered back to their issuers through an ID FIFO.
module fpnew_opgroup_slice_arbiter
  import fpnew_opgroup_slice_arbiter_pkg::*;
#(
  parameter int unsigned  NumReq         = DefaultNumReq,
  parameter int unsigned  OpWidth        = DefaultOpWidth,
  parameter int unsigned  ResWidth       = DefaultResWidth,
  parameter int unsigned  MaxOutstanding = DefaultMaxOutstanding,
  localparam int unsigned IdWidth        = $clog2(NumReq),
  localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq-1:0][OpWidth-1:0] req_op_i,
  output logic                           slc_valid_o,
  input  logic                           slc_ready_i,
  output logic [OpWidth-1:0]             slc_op_o,
  input  logic                           slc_out_valid_i,
  output logic                           slc_out_ready_o,
  input  logic [ResWidth-1:0]            slc_result_i,
  output logic [NumReq-1:0]              rsp_valid_o,
  input  logic [NumReq-1:0]              rsp_ready_i,
  output logic [ResWidth-1:0]            rsp_result_o,
  input  logic                           flush_i,
  output logic                           slc_flush_o,
  output logic                           busy_o,
  output logic [CntWidth-1:0]            outstanding_o
);

  logic                rst_q;
  logic                active;
  logic                lock_q, lock_d;
  logic [IdWidth-1:0]  locked_id_q, locked_id_d;
  logic [IdWidth-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdWidth-1:0]  rr_grant, cand, grant, head;
  logic                rr_found;
  logic [CntWidth-1:0] count;
  logic                empty, full, can_issue, fire, pop, flush;

  // Outputs stay quiet during reset and for one cycle after it.
  assign active    = ~(rst_i | rst_q);
  assign flush     = active & flush_i;
  assign full      = (count == CntWidth'(MaxOutstanding));
  assign empty     = (count == '0);
  assign can_issue = active & ~full & ~flush_i;

  always_comb begin
    rr_grant = rr_ptr_q;
    rr_found = 1'b0;
    cand     = rr_ptr_q;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = IdWidth'(wrap_add(32'(rr_ptr_q), k, NumReq));
      if (!rr_found && req_valid_i[cand]) begin
        rr_found = 1'b1;
        rr_grant = cand;
      end
    end
  end

  // A held offer keeps its grant so the slice sees a stable op until accepted.
  assign grant       = lock_q ? locked_id_q : rr_grant;
  assign slc_valid_o = can_issue & req_valid_i[grant];
  assign slc_op_o    = active ? req_op_i[grant] : '0;
  assign fire        = slc_valid_o & slc_ready_i;
  assign req_ready_o = fire ? (NumReq'(1) << grant) : '0;

  always_comb begin
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush || fire) begin
      lock_d = 1'b0;
    end else if (slc_valid_o) begin
      lock_d      = 1'b1;
      locked_id_d = grant;
    end
    if (fire) begin
      rr_ptr_d = IdWidth'(wrap_add(32'(grant), 1, NumReq));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_q       <= 1'b1;
      lock_q      <= 1'b0;
      locked_id_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rst_q       <= 1'b0;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  fpnew_slice_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdWidth)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fire),
    .push_data_i (grant),
    .pop_i       (pop),
    .clear_i     (flush),
    .head_o      (head),
    .count_o     (count)
  );

  // During a flush the slice drains freely; nothing is delivered or popped.
  assign slc_out_ready_o = active & (flush_i | (rsp_ready_i[head] & ~empty));
  assign rsp_valid_o     = (active & slc_out_valid_i & ~empty & ~flush_i) ?
                           (NumReq'(1) << head) : '0;
  assign pop             = slc_out_valid_i & slc_out_ready_o & ~flush_i;
  assign rsp_result_o    = active ? slc_result_i : '0;
  assign slc_flush_o     = flush;
  assign busy_o          = active & (~empty | slc_valid_o);
  assign outstanding_o   = count;

  a_no_result_when_empty: assert property (
    @(posedge clk_i) disable iff (!active) !(slc_out_valid_i && empty));

endmodule

// File: tb/tb_fpnew_opgroup_slice_arbiter.sv
// Randomized bench: issue-side reference model plus response scoreboard/monitor.
module tb_fpnew_opgroup_slice_arbiter;

  localparam int unsigned N      = 4;
  localparam int unsigned OpW    = 128;
  localparam int unsigned ResW   = 72;
  localparam int unsigned MaxOut = 4;
  localparam int unsigned CntW   = $clog2(MaxOut + 1);
  localparam int          Lat    = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]            req_valid, req_ready;
  logic [N-1:0][OpW-1:0]   req_op;
  logic                    slc_valid, slc_ready, slc_out_valid, slc_out_ready, slc_flush, busy;
  logic [OpW-1:0]          slc_op;
  logic [ResW-1:0]         slc_result, rsp_result;
  logic [N-1:0]            rsp_valid, rsp_ready;
  logic                    flush;
  logic [CntW-1:0]         outstanding;

  always #5 clk = ~clk;

  fpnew_opgroup_slice_arbiter #(
    .NumReq         (N),
    .OpWidth        (OpW),
    .ResWidth       (ResW),
    .MaxOutstanding (MaxOut)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_op_i        (req_op),
    .slc_valid_o     (slc_valid),
    .slc_ready_i     (slc_ready),
    .slc_op_o        (slc_op),
    .slc_out_valid_i (slc_out_valid),
    .slc_out_ready_o (slc_out_ready),
    .slc_result_i    (slc_result),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_result_o    (rsp_result),
    .flush_i         (flush),
    .slc_flush_o     (slc_flush),
    .busy_o          (busy),
    .outstanding_o   (outstanding)
  );

  typedef struct { int id; logic [ResW-1:0] res; } exp_t;
  typedef struct { logic [ResW-1:0] res; int due; } slc_t;

  exp_t sb[$];           // expected responses in delivery order
  int   ids[$];          // requesters with ops in flight, oldest first
  slc_t slq[$];          // slice pipeline contents
  int   dut_grants[$], rsp_order[$];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int m_ptr = 0, m_pending = -1, m_count = 0;
  bit rst_cmd, rst_prev, rr_phase;
  int p_req, p_rdy, p_out, p_rsp, p_flush;
  bit e_valid, e_fire, e_pop, s_flush, d_fire, d_outfire;
  int e_grant;
  logic [OpW-1:0] d_op;

  function automatic void chk(string name, logic [OpW-1:0] got, logic [OpW-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic logic [ResW-1:0] f_res(logic [OpW-1:0] op);
    return op[ResW-1:0] ^ op[OpW-1:OpW-ResW] ^ 72'h5a_c3a5_5a3c_0ff0_1234;
  endfunction

  function automatic logic [OpW-1:0] rand_op();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    int  g, c;
    bit  found, act;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_ptr = 0; m_pending = -1;
      ids.delete(); sb.delete(); slq.delete();
    end else if (s_flush) begin
      m_pending = -1;
      ids.delete(); sb.delete(); slq.delete();
    end else begin
      if (e_fire) begin
        ids.push_back(e_grant);
        sb.push_back('{id: e_grant, res: f_res(req_op[e_grant])});
        m_ptr = (e_grant + 1) % N;
        m_pending = -1;
        req_valid[e_grant] = 1'b0;
      end else if (e_valid) begin
        m_pending = e_grant;
      end
      if (e_pop) void'(ids.pop_front());
      if (d_outfire) void'(slq.pop_front());
      if (d_fire) slq.push_back('{res: f_res(d_op), due: cyc + Lat - 1});
    end
    m_count  = ids.size();
    rst_prev = rst;
    rst      = rst_cmd;
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] && $urandom_range(99) < p_req) begin
        req_valid[i] = 1'b1;
        req_op[i]    = rand_op();
      end
    end
    slc_ready     = ($urandom_range(99) < p_rdy);
    slc_out_valid = (slq.size() > 0) && (slq[0].due <= cyc) && ($urandom_range(99) < p_out);
    slc_result    = slc_out_valid ? slq[0].res : ResW'({$urandom(), $urandom(), $urandom()});
    for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(99) < p_rsp);
    flush = !rst && !rst_prev && ($urandom_range(999) < p_flush);

    @(negedge clk);
    act = !(rst || rst_prev);
    g = m_ptr;
    found = 1'b0;
    if (m_pending >= 0) begin
      g = m_pending;
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && req_valid[c]) begin g = c; found = 1'b1; end
      end
    end
    e_grant   = g;
    e_valid   = act && (m_count < MaxOut) && !flush && req_valid[g];
    e_fire    = e_valid && slc_ready;
    e_pop     = act && !flush && slc_out_valid && (ids.size() > 0) && rsp_ready[ids[0]];
    s_flush   = act && flush;
    d_fire    = slc_valid && slc_ready;
    d_op      = slc_op;
    d_outfire = slc_out_valid && slc_out_ready;

    chk("slc_valid", slc_valid, e_valid);
    if (e_valid) chk("slc_op", slc_op, req_op[g]);
    chk("req_ready", req_ready, e_fire ? (N'(1) << g) : '0);
    chk("slc_out_ready", slc_out_ready,
        act && (flush || ((ids.size() > 0) && rsp_ready[ids[0]])));
    chk("rsp_valid", rsp_valid,
        (act && !flush && slc_out_valid && ids.size() > 0) ? (N'(1) << ids[0]) : '0);
    chk("slc_flush", slc_flush, s_flush);
    chk("busy", busy, act && (m_count != 0 || e_valid));
    chk("outstanding", outstanding, m_count);
    if (rr_phase && req_ready != '0) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) dut_grants.push_back(i);
    end
  endtask

  // Response monitor: every delivered result must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, '0);
        end else begin
          chk("rsp_id", rsp_valid, N'(1) << sb[0].id);
          if ((rsp_valid & rsp_ready) != '0) begin
            chk("rsp_result", rsp_result, sb[0].res);
            if (rr_phase) rsp_order.push_back(sb[0].id);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};
    rst = 1'b1; rst_cmd = 1'b1; rst_prev = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) req_op[i] = rand_op();
    slc_ready = 1'b0; slc_out_valid = 1'b0; slc_result = '0;
    rsp_ready = '0; flush = 1'b0;
    e_valid = 0; e_fire = 0; e_pop = 0; s_flush = 0; d_fire = 0; d_outfire = 0;
    e_grant = 0; d_op = '0;
    p_req = 100; p_rdy = 100; p_out = 100; p_rsp = 100; p_flush = 0;
    rr_phase = 1'b1;

    // Reset with every requester asserting, then free-running round robin.
    repeat (3) step();
    rst_cmd = 1'b0;
    repeat (14) step();
    rr_phase = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < dut_grants.size()) chk("rr_grant_order", dut_grants[i], exp_seq[i]);
      else chk("rr_grant_missing", dut_grants.size(), 5);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < rsp_order.size()) chk("rr_rsp_order", rsp_order[i], i);
      else chk("rr_rsp_missing", rsp_order.size(), 4);
    end

    // Issue backpressure: offers held and locked.
    p_req = 50; p_rdy = 30;
    repeat (300) step();

    // Slice output stalls until the ID FIFO fills.
    p_req = 100; p_rdy = 100; p_out = 0;
    repeat (20) step();
    chk("full_outstanding", outstanding, MaxOut);
    chk("full_no_issue", slc_valid, 1'b0);
    p_out = 100;
    repeat (40) step();

    // Response backpressure.
    p_req = 70; p_rdy = 70; p_rsp = 30;
    repeat (300) step();

    // Flushes mixed with all other traffic.
    p_flush = 40; p_rdy = 50; p_out = 60; p_rsp = 60;
    repeat (600) step();

    for (int r = 0; r < 4; r++) begin
      p_req = $urandom_range(100, 10); p_rdy = $urandom_range(100, 10);
      p_out = $urandom_range(100, 10); p_rsp = $urandom_range(100, 10);
      p_flush = $urandom_range(20);
      repeat (400) step();
    end

    // Drain everything still pending, with a cycle budget.
    p_req = 0; p_rdy = 100; p_out = 100; p_rsp = 100; p_flush = 0;
    for (int i = 0; i < 200 && (req_valid != '0 || sb.size() > 0); i++) step();
    step();
    chk("drain_scoreboard_empty", sb.size(), 0);
    chk("drain_outstanding", outstanding, 0);
    chk("drain_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
